// File: rtl/lcd_fb_writer.sv
// Byte-to-pixel serialiser feeding the 1-bit LCD frame RAM at an auto-incrementing, wrapping address.
// Define LCD_BLANK_WR_EN to hold RAM writes off while H_DONE && V_DONE mark the active display window.
module lcd_fb_writer #(
  parameter int FB_DEPTH = 38400,
  parameter int ADDR_W   = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              frame_start,
  input  logic              H_DONE,
  input  logic              V_DONE,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_din,
  output logic              ram_we,
  output logic              frame_done,
  output logic              busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_DEPTH - 1);

  logic [0:0]        state;
  logic [7:0]        shift_reg;
  logic [2:0]        bit_idx;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] next_ptr;
  logic              accept;
  logic              stall;

`ifdef LCD_BLANK_WR_EN
  // Ready only from IDLE, so a new byte never overlaps a possibly stalled one.
  localparam logic EARLY_READY = 1'b0;
  assign stall = H_DONE && V_DONE;
`else
  localparam logic EARLY_READY = 1'b1;
  logic unused_window;
  assign unused_window = H_DONE ^ V_DONE;
  assign stall = 1'b0;
`endif

  assign accept   = wr_valid && wr_ready;
  assign next_ptr = (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
  assign busy     = (state == SHIFT);

  // The RAM-side outputs register the pixel chosen by the SHIFT state, one pixel per unstalled cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_idx    <= 3'd7;
      ptr        <= '0;
      ram_addr   <= '0;
      ram_din    <= 1'b0;
      ram_we     <= 1'b0;
      wr_ready   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ram_we     <= 1'b0;
      frame_done <= ram_we && (ram_addr == LAST_ADDR);
      if (state == IDLE) begin
        if (frame_start) begin
          ptr <= '0;
        end
        if (accept) begin
          shift_reg <= wr_data;
          bit_idx   <= 3'd7;
          state     <= SHIFT;
          wr_ready  <= 1'b0;
        end else begin
          wr_ready <= 1'b1;
        end
      end else begin
        if (frame_start) begin
          ptr      <= '0;
          bit_idx  <= 3'd7;
          state    <= IDLE;
          wr_ready <= 1'b0;
        end else if (!stall) begin
          ram_we   <= 1'b1;
          ram_din  <= shift_reg[bit_idx];
          ram_addr <= ptr;
          ptr      <= next_ptr;
          if (bit_idx == 3'd0) begin
            bit_idx <= 3'd7;
            if (accept) begin
              shift_reg <= wr_data;
              wr_ready  <= 1'b0;
            end else begin
              state    <= IDLE;
              wr_ready <= 1'b1;
            end
          end else begin
            bit_idx  <= bit_idx - 1'b1;
            wr_ready <= EARLY_READY && (bit_idx == 3'd1);
          end
        end
      end
    end
  end

endmodule
